router_sync_n: RTL
==================

# router_sync_n

Parametrised write-steering and read-timeout controller for the packet router. It latches the destination address from the header and steers the write enable to one of `NUM_CH` output FIFOs, muxing that FIFO's full flag back to the FSM. It also runs an independent read-timeout timer per channel, which issues a one-cycle soft reset when a channel's data sits unread too long. It sits between the router FSM/register block and the `NUM_CH` output FIFOs, and adds invalid-address detection, address locking and a configurable timeout.

## Interface
- `NUM_CH`, default 3: number of output channels, 2..8.
- `ADDR_W`, default 2: header address width; must satisfy 2^`ADDR_W` >= `NUM_CH`.
- `TIMEOUT`, default 30: consecutive unread-valid cycles before a soft reset, 2..255.
- `CNT_W`, default 5: timer width; must satisfy 2^`CNT_W` >= `TIMEOUT`.

Ports:
- `clock` in 1: rising-edge clock.
- `resetn` in 1: reset, synchronous, active-low.
- `detect_add` in 1: header-byte strobe from the FSM.
- `data_in` in `ADDR_W`: address field of the header.
- `write_enb_reg` in 1: FSM write request.
- `empty` in `NUM_CH`: per-FIFO empty flags.
- `full` in `NUM_CH`: per-FIFO full flags.
- `read_enb` in `NUM_CH`: per-channel read enables from the downstream readers.
- `write_enb` out `NUM_CH`: one-hot FIFO write enable; combinational.
- `fifo_full` out 1: full flag of the addressed FIFO; combinational.
- `vld_out` out `NUM_CH`: per-channel data-valid, equal to ~`empty`; combinational.
- `soft_reset` out `NUM_CH`: per-channel timeout flush pulse; registered.
- `addr_err` out 1: the latched address is >= `NUM_CH`; registered.

## Operation
- Address register `addr` (`ADDR_W` bits):
  - Loads `data_in` on a clock edge where `detect_add`=1 and `write_enb_reg`=0.
  - `detect_add` is ignored while `write_enb_reg`=1 (address locked mid-packet).
- `addr_err` is updated on every load: it is set to (`data_in` >= `NUM_CH`) and holds until the next load.
- `write_enb[i]` = `write_enb_reg` & (`addr`==i) & ~`addr_err`, so at most one bit is ever high.
- `fifo_full` = `full[addr]` when `addr_err`=0, else 0. This lets the FSM drain a misaddressed packet without stalling.
- `vld_out` = ~`empty`, purely combinational.
- Per-channel timer FSM, one instance per channel; states are IDLE, COUNT, FLUSH:
  - IDLE: `vld_out[i]`=0, count=0. Goes to COUNT when `vld_out[i]`=1 and `read_enb[i]`=0, loading count=1.
  - COUNT, on each cycle:
    - `vld_out[i]`=0 -> IDLE, count=0.
    - `read_enb[i]`=1 -> count=0 and stay in COUNT. A read restarts the window, and the restart cycle does not count.
    - count==`TIMEOUT`-1 with no read -> FLUSH, count=0.
    - otherwise count+1.
  - FLUSH: `soft_reset[i]`=1 for exactly this one cycle. Next state is COUNT with count=1 if `vld_out[i]`=1 and `read_enb[i]`=0, otherwise IDLE.
- `soft_reset[i]` is high only in FLUSH.
- The count never exceeds `TIMEOUT`-1 and never wraps.
- Channels are fully independent; simultaneous timeouts on several channels are allowed.

## Timing
- Reset values: `addr`=0, `addr_err`=0, all timers IDLE with count=0, `soft_reset`=0.
  - With `write_enb_reg`=0 during reset, `write_enb`=0.
  - `fifo_full` and `vld_out` follow their inputs combinationally even during reset.
- Address latency: a load at edge k steers `write_enb` from cycle k+1 onward.
  - `detect_add` and `write_enb_reg` high in the same cycle: no load occurs, and the old address steers that cycle.
- Timeout latency: `soft_reset[i]` rises on the edge after the `TIMEOUT`-th consecutive cycle with `vld_out[i]`=1 and `read_enb[i]`=0.
- `read_enb[i]` high in the cycle the count hits `TIMEOUT`-1 suppresses the flush.
- `resetn` low mid-count: on the next edge the timers return to IDLE, `soft_reset` goes to 0, and `addr` and `addr_err` clear.

## Structure
- Package `router_pkg`:
  - timer state enum `tmr_state_t` (IDLE, COUNT, FLUSH);
  - default constants `ROUTER_NUM_CH`=3 and `ROUTER_TIMEOUT`=30.
- Sub-module `router_sync_timer` (params `TIMEOUT`, `CNT_W`; ports `clock`, `resetn`, `vld`, `rd`, `soft_reset`). It is instantiated `NUM_CH` times in a generate loop.
- The top level holds `addr`, `addr_err`, the write-enable decode and the full mux.

## Test plan
- Reset, then `detect_add`=1 with `data_in`=2 -> next cycle, `write_enb_reg`=1 gives `write_enb`=3'b100 and `fifo_full` follows `full[2]`. All outputs read 0 during reset.
- Load `data_in`=3 with `NUM_CH`=3 -> `addr_err`=1, `write_enb`=0 even when `write_enb_reg`=1, `fifo_full`=0 even with `full`=3'b111.
- `detect_add` with `data_in`=1 while `write_enb_reg`=1 and the latched address is 0 -> address stays 0 and `write_enb`=3'b001.
- `empty[0]`=0 with no reads for 30 cycles -> `soft_reset[0]` is high on cycle 31 for exactly 1 cycle. A read pulse on cycle 29 instead gives no pulse, and the next pulse arrives 30 unread cycles later.
- Timers counting on channels 0 and 2, `resetn` pulsed low at count 15 -> both timers restart, and `soft_reset` is 0 until 30 new unread cycles have elapsed.
- `NUM_CH`=4, `ADDR_W`=2, `TIMEOUT`=5 -> `data_in`=3 steers `write_enb`=4'b1000, and channel 3 times out on cycle 6.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and default constants for the packet router write-steering
// and read-timeout controller.
package router_pkg;

    // Per-channel read-timeout timer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FLUSH = 2'd2
    } tmr_state_t;

    localparam int ROUTER_NUM_CH   = 3;
    localparam int ROUTER_TIMEOUT  = 30;

endpackage

// File: rtl/router_sync_timer.sv
// Read-timeout timer for one output channel. Counts consecutive cycles in
// which the channel holds valid data that nobody reads, and issues a single
// cycle soft_reset pulse once that run reaches TIMEOUT cycles.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = ROUTER_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    tmr_state_t       state;
    logic [CNT_W-1:0] count;

    // Timer FSM; soft_reset is registered so it is high exactly while in FLUSH
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            count      <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (vld && !rd) begin
                        state <= COUNT;
                        count <= ONE;
                    end else begin
                        count <= '0;
                    end
                end
                COUNT: begin
                    if (!vld) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (rd) begin
                        // a read restarts the window; this cycle is not counted
                        count <= '0;
                    end else if (count == LAST) begin
                        state      <= FLUSH;
                        count      <= '0;
                        soft_reset <= 1'b1;
                    end else begin
                        count <= count + ONE;
                    end
                end
                FLUSH: begin
                    if (vld && !rd) begin
                        state <= COUNT;
                        count <= ONE;
                    end else begin
                        state <= IDLE;
                        count <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/router_sync_n.sv
// Write-steering and read-timeout controller for the packet router.
// Latches the header address, steers the FSM write request to one output
// FIFO, muxes that FIFO's full flag back, and runs one timeout timer per
// channel. Misaddressed packets never write and never report full, so the
// FSM can drain them without stalling.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_CH  = ROUTER_NUM_CH,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = ROUTER_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] read_enb,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    // One extra bit so the range check works when NUM_CH == 2**ADDR_W
    localparam logic [ADDR_W:0] NUM_CH_X = (ADDR_W + 1)'(NUM_CH);

    logic [ADDR_W-1:0] addr;

    // Address latch; locked while a packet is being written
    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr     <= '0;
            addr_err <= 1'b0;
        end else if (detect_add && !write_enb_reg) begin
            addr     <= data_in;
            addr_err <= ({1'b0, data_in} >= NUM_CH_X);
        end
    end

    // One-hot write decode and full-flag mux for the latched address
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == ADDR_W'(i)) begin
                write_enb[i] = write_enb_reg && !addr_err;
                fifo_full    = full[i] && !addr_err;
            end
        end
    end

    assign vld_out = ~empty;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_timer
            router_sync_timer #(
                .TIMEOUT (TIMEOUT),
                .CNT_W   (CNT_W)
            ) u_timer (
                .clock      (clock),
                .resetn     (resetn),
                .vld        (vld_out[g]),
                .rd         (read_enb[g]),
                .soft_reset (soft_reset[g])
            );
        end
    endgenerate

endmodule
